// File: rtl/mem_responder.sv
// mem_responder: 2^ADR_W x DATA_W word store answering CPU rd_mem/wr_mem
// requests, plus a host byte-stream loader that fills the store from
// address 0 while holding the CPU in reset via cpu_hold.
// Optional feature: define MEM_ROM_PROTECT_EN to discard CPU writes below
// ROM_TOP and flag them on the sticky wp_fault output.
module mem_responder #(
    parameter int ADR_W   = 6,
    parameter int DATA_W  = 8,
    parameter int ROM_TOP = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADR_W-1:0]  adr_bus,
    input  logic              rd_mem,
    input  logic              wr_mem,
    input  logic [DATA_W-1:0] data_bus_in,
    output logic [DATA_W-1:0] data_bus_out,
    input  logic              ld_start,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_byte,
    input  logic              ld_last,
    output logic              ld_ready,
    output logic              cpu_hold,
    output logic              ld_done,
    output logic [ADR_W:0]    ld_count,
    output logic              wp_fault
);

    localparam int DEPTH = 1 << ADR_W;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_LOAD = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_next_state;
    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [ADR_W-1:0]  r_ptr;
    logic [ADR_W:0]    r_ld_count;
    logic [DATA_W-1:0] r_data_out;
    logic              r_ld_ready;
    logic              r_cpu_hold;
    logic              r_ld_done;

    logic w_accept;
    logic w_ptr_end;
    logic w_finish;
    logic w_cpu_rd;
    logic w_cpu_wr_req;
    logic w_wp_hit;
    logic w_cpu_wr;

    // A byte is taken only in LOAD with ready high; a restart pulse drops it.
    assign w_accept     = (r_state == S_LOAD) && ld_valid && r_ld_ready && !ld_start;
    assign w_ptr_end    = (r_ptr == {ADR_W{1'b1}});
    // The pointer never wraps: the byte written to the top address ends the load.
    assign w_finish     = w_accept && (ld_last || w_ptr_end);
    // A simultaneous read and write performs only the write.
    assign w_cpu_rd     = (r_state == S_IDLE) && rd_mem && !wr_mem;
    assign w_cpu_wr_req = (r_state == S_IDLE) && wr_mem;

`ifdef MEM_ROM_PROTECT_EN
    logic r_wp_fault;

    assign w_wp_hit = w_cpu_wr_req && (32'(adr_bus) < ROM_TOP);

    // Sticky protect-violation flag, cleared by reset or a new load.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wp_fault <= 1'b0;
        end else if (ld_start) begin
            r_wp_fault <= 1'b0;
        end else if (w_wp_hit) begin
            r_wp_fault <= 1'b1;
        end
    end

    assign wp_fault = r_wp_fault;
`else
    assign w_wp_hit = 1'b0;
    assign wp_fault = 1'b0;
`endif

    assign w_cpu_wr = w_cpu_wr_req && !w_wp_hit;

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state logic: enter LOAD on ld_start, leave on the final accepted byte.
    always_comb begin
        // NOTE: default assigned first so no path leaves it unassigned (no latch).
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (ld_start) w_next_state = S_LOAD;
            S_LOAD: begin
                if (ld_start) begin
                    w_next_state = S_LOAD;
                end else if (w_finish) begin
                    w_next_state = S_IDLE;
                end
            end
            default: w_next_state = S_IDLE;
        endcase
    end

    // Loader pointer/count, registered handshake flags and CPU read data.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr      <= '0;
            r_ld_count <= '0;
            r_ld_ready <= 1'b0;
            r_cpu_hold <= 1'b0;
            r_ld_done  <= 1'b0;
            r_data_out <= '0;
        end else begin
            r_ld_ready <= (w_next_state == S_LOAD);
            r_cpu_hold <= (w_next_state == S_LOAD);
            r_ld_done  <= w_finish;
            if (ld_start) begin
                r_ptr      <= '0;
                r_ld_count <= '0;
            end else if (w_accept) begin
                r_ptr      <= r_ptr + 1'b1;
                r_ld_count <= r_ld_count + 1'b1;
            end
            if (w_cpu_rd) begin
                r_data_out <= r_mem[adr_bus];
            end
        end
    end

    // Single write port shared by the loader (LOAD) and the CPU (IDLE).
    always_ff @(posedge clk) begin
        // NOTE: the array has no reset; its contents survive reset by design.
        if (!reset) begin
            if (w_accept) begin
                r_mem[r_ptr] <= ld_byte;
            end else if (w_cpu_wr) begin
                r_mem[adr_bus] <= data_bus_in;
            end
        end
    end

    assign data_bus_out = r_data_out;
    assign ld_ready     = r_ld_ready;
    assign cpu_hold     = r_cpu_hold;
    assign ld_done      = r_ld_done;
    assign ld_count     = r_ld_count;

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench for mem_responder: reset values, CPU
// read/write, loader streams (ld_last, auto-finish at top address),
// simultaneous read+write, write protection and reset during a load.
module tb_mem_responder;

    localparam int ADR_W  = 6;
    localparam int DATA_W = 8;

    logic              clk;
    logic              reset;
    logic [ADR_W-1:0]  adr_bus;
    logic              rd_mem;
    logic              wr_mem;
    logic [DATA_W-1:0] data_bus_in;
    logic [DATA_W-1:0] data_bus_out;
    logic              ld_start;
    logic              ld_valid;
    logic [DATA_W-1:0] ld_byte;
    logic              ld_last;
    logic              ld_ready;
    logic              cpu_hold;
    logic              ld_done;
    logic [ADR_W:0]    ld_count;
    logic              wp_fault;

    int n_tests;
    int n_fail;
    int hold_cycles;

    mem_responder #(.ADR_W(ADR_W), .DATA_W(DATA_W), .ROM_TOP(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .adr_bus      (adr_bus),
        .rd_mem       (rd_mem),
        .wr_mem       (wr_mem),
        .data_bus_in  (data_bus_in),
        .data_bus_out (data_bus_out),
        .ld_start     (ld_start),
        .ld_valid     (ld_valid),
        .ld_byte      (ld_byte),
        .ld_last      (ld_last),
        .ld_ready     (ld_ready),
        .cpu_hold     (cpu_hold),
        .ld_done      (ld_done),
        .ld_count     (ld_count),
        .wp_fault     (wp_fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Counts one comparison and reports a mismatch.
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // CPU read of one address; data is valid after the sampling edge.
    task automatic cpu_read(input logic [ADR_W-1:0] a);
        adr_bus = a;
        rd_mem  = 1'b1;
        tick();
        rd_mem  = 1'b0;
    endtask

    task automatic cpu_write(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] d);
        adr_bus     = a;
        data_bus_in = d;
        wr_mem      = 1'b1;
        tick();
        wr_mem      = 1'b0;
    endtask

    task automatic start_load();
        ld_start = 1'b1;
        tick();
        ld_start = 1'b0;
    endtask

    initial begin
        n_tests     = 0;
        n_fail      = 0;
        reset       = 1'b1;
        adr_bus     = '0;
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        data_bus_in = '0;
        ld_start    = 1'b0;
        ld_valid    = 1'b0;
        ld_byte     = '0;
        ld_last     = 1'b0;

        // Reset state.
        tick();
        tick();
        check("rst_data_out", 32'(data_bus_out), 32'h0);
        check("rst_ld_ready", 32'(ld_ready), 32'h0);
        check("rst_cpu_hold", 32'(cpu_hold), 32'h0);
        check("rst_ld_done",  32'(ld_done), 32'h0);
        check("rst_ld_count", 32'(ld_count), 32'h0);
        check("rst_wp_fault", 32'(wp_fault), 32'h0);
        reset = 1'b0;
        tick();

        // Zero-fill addresses 0..5 through the loader, then read address 5.
        start_load();
        check("z_hold_on",  32'(cpu_hold), 32'h1);
        check("z_ready_on", 32'(ld_ready), 32'h1);
        for (int i = 0; i < 6; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'h00;
            ld_last  = (i == 5);
            tick();
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("z_done",  32'(ld_done), 32'h1);
        check("z_count", 32'(ld_count), 32'd6);
        tick();
        check("z_done_pulse", 32'(ld_done), 32'h0);
        cpu_read(6'd5);
        check("rd5_zero", 32'(data_bus_out), 32'h00);

        // Three-byte load with ld_last on the third byte.
        hold_cycles = 0;
        start_load();
        if (cpu_hold) hold_cycles++;
        for (int i = 0; i < 3; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'h10 + 8'(i);
            ld_last  = (i == 2);
            tick();
            if (cpu_hold) hold_cycles++;
        end
        ld_valid = 1'b0;
        ld_last  = 1'b0;
        check("l3_hold_cycles", 32'(hold_cycles), 32'd3);
        check("l3_done",        32'(ld_done), 32'h1);
        check("l3_ready_off",   32'(ld_ready), 32'h0);
        check("l3_count",       32'(ld_count), 32'd3);
        tick();
        for (int i = 0; i < 3; i++) begin
            cpu_read(6'(i));
            check($sformatf("l3_rd%0d", i), 32'(data_bus_out), 32'h10 + 32'(i));
        end

        // 64 bytes without ld_last: auto-finish after address 63.
        start_load();
        for (int i = 0; i < 64; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'h80 + 8'(i);
            ld_last  = 1'b0;
            tick();
        end
        check("l64_done",  32'(ld_done), 32'h1);
        check("l64_count", 32'(ld_count), 32'd64);
        check("l64_ready", 32'(ld_ready), 32'h0);
        ld_byte = 8'hEE;
        tick();
        ld_valid = 1'b0;
        check("l64_done_pulse", 32'(ld_done), 32'h0);
        check("l64_hold_off",   32'(cpu_hold), 32'h0);
        cpu_read(6'd0);
        check("l64_rd0_nowrap", 32'(data_bus_out), 32'h80);
        cpu_read(6'd63);
        check("l64_rd63", 32'(data_bus_out), 32'hBF);

        // CPU write/read, then simultaneous read+write.
        cpu_write(6'd20, 8'hA5);
        cpu_read(6'd20);
        check("wr20_rd", 32'(data_bus_out), 32'hA5);
        adr_bus     = 6'd20;
        data_bus_in = 8'h5A;
        rd_mem      = 1'b1;
        wr_mem      = 1'b1;
        tick();
        rd_mem      = 1'b0;
        wr_mem      = 1'b0;
        check("rdwr_hold_out", 32'(data_bus_out), 32'hA5);
        tick();
        check("idle_hold_out", 32'(data_bus_out), 32'hA5);
        cpu_read(6'd20);
        check("rdwr_written", 32'(data_bus_out), 32'h5A);

        // Write into the protected region (address 3 holds 0x83 from the 64-byte load).
        cpu_write(6'd3, 8'hFF);
        cpu_read(6'd3);
`ifdef MEM_ROM_PROTECT_EN
        check("wp_mem3",  32'(data_bus_out), 32'h83);
        check("wp_fault", 32'(wp_fault), 32'h1);
`else
        check("wp_mem3",  32'(data_bus_out), 32'hFF);
        check("wp_fault", 32'(wp_fault), 32'h0);
`endif

        // Reset after 2 of 5 bytes; ld_start also clears any protect fault.
        start_load();
        check("rl_wp_cleared", 32'(wp_fault), 32'h0);
        for (int i = 0; i < 2; i++) begin
            ld_valid = 1'b1;
            ld_byte  = 8'h30 + 8'(i);
            ld_last  = 1'b0;
            tick();
        end
        check("rl_count2", 32'(ld_count), 32'd2);
        check("rl_hold_on", 32'(cpu_hold), 32'h1);
        reset    = 1'b1;
        ld_byte  = 8'h32;
        tick();
        ld_valid = 1'b0;
        reset    = 1'b0;
        check("rl_hold_off",  32'(cpu_hold), 32'h0);
        check("rl_ready_off", 32'(ld_ready), 32'h0);
        tick();
        cpu_read(6'd0);
        check("rl_rd0", 32'(data_bus_out), 32'h30);
        cpu_read(6'd1);
        check("rl_rd1", 32'(data_bus_out), 32'h31);
        cpu_read(6'd2);
        check("rl_rd2_untouched", 32'(data_bus_out), 32'h82);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_responder.md
# mem_responder

Memory-side responder for the adding-machine CPU bus. It holds a 64 x 8 word store and answers the CPU's `rd_mem`/`wr_mem` requests on `adr_bus`. It also contains a byte-stream loader that fills the store from a host while holding the CPU in reset. It sits between the CPU and the top-level testbench/host: the CPU's `data_bus_out` feeds `data_bus_in`, and `data_bus_out` feeds the CPU's `data_bus_in`.

## Interface
Parameters:
- `ADR_W`, 6: address width; depth is 2^ADR_W.
- `DATA_W`, 8: word width.
- `ROM_TOP`, 16: first writable address; used only when `MEM_ROM_PROTECT_EN` is defined.

Ports:
- `clk`  in  1  single clock; everything is rising-edge.
- `reset`  in  1  synchronous, active-high.
- `adr_bus`  in  ADR_W  CPU address.
- `rd_mem`  in  1  CPU read strobe.
- `wr_mem`  in  1  CPU write strobe.
- `data_bus_in`  in  DATA_W  CPU write data.
- `data_bus_out`  out  DATA_W  read data returned to the CPU.
- `ld_start`  in  1  one-cycle pulse that begins a load at address 0.
- `ld_valid`  in  1  host byte valid.
- `ld_byte`  in  DATA_W  host byte.
- `ld_last`  in  1  qualifies the final byte of a load.
- `ld_ready`  out  1  loader accepts a byte this cycle.
- `cpu_hold`  out  1  drives the CPU reset during a load.
- `ld_done`  out  1  one-cycle pulse when a load completes.
- `ld_count`  out  ADR_W+1  number of bytes written by the current or last load.
- `wp_fault`  out  1  sticky protect-violation flag.

## Operation
- FSM has two states, IDLE and LOAD. `reset` forces IDLE.
- Reset values: `data_bus_out`=0, `ld_ready`=0, `cpu_hold`=0, `ld_done`=0, `ld_count`=0, `wp_fault`=0. Array contents are never cleared by `reset`.
- IDLE, CPU access:
  - `rd_mem` sampled high: `data_bus_out <= mem[adr_bus]`.
  - `wr_mem` sampled high: `mem[adr_bus] <= data_bus_in`.
  - Both high in the same cycle: the write is performed and `data_bus_out` holds its previous value.
  - `data_bus_out` holds its value between reads.
- IDLE + `ld_start`:
  - Go to LOAD.
  - Pointer = 0, `ld_count` = 0.
  - `cpu_hold` = 1 and `ld_ready` = 1 from the next cycle.
- LOAD:
  - Each cycle with `ld_valid` && `ld_ready`: `mem[ptr] <= ld_byte`, ptr++, `ld_count`++.
  - `rd_mem`/`wr_mem` are ignored and `data_bus_out` is frozen.
- LOAD exit: when the accepted byte has `ld_last`=1, or is written to address 2^ADR_W-1:
  - Go to IDLE.
  - `ld_done` pulses for one cycle.
  - `ld_ready` and `cpu_hold` drop in that same cycle.
  - `ld_count` holds its final value (1..64).
- The pointer never wraps. A 64th byte ends the load even if `ld_last`=0.
- `ld_start` during LOAD restarts the load: ptr = 0, `ld_count` = 0. A byte offered in that same cycle is dropped.
- `reset` during LOAD: IDLE next cycle, `cpu_hold`=0. Bytes already written remain.

## Timing
- Read latency is 1 cycle: address and `rd_mem` sampled at edge N, data valid after edge N and held. The controller keeps `adr_bus` stable for its fetch state.
- A write commits at the sampling edge. A read of the same address on the following cycle returns the new data.
- Loader throughput is one byte per cycle. `ld_ready` is registered and depends only on state.
- `ld_done` is high for exactly one cycle, the cycle after the final acceptance edge.

## Configuration
- `MEM_ROM_PROTECT_EN` defined:
  - CPU writes to addresses < `ROM_TOP` are discarded and set `wp_fault`=1.
  - `wp_fault` is cleared only by `reset` or `ld_start`.
  - The loader may write all addresses.
- `MEM_ROM_PROTECT_EN` not defined: all CPU writes succeed and `wp_fault` is tied to 0.

## Test plan
- Reset, then `rd_mem` at address 5 with mem[5]=0x00 -> `data_bus_out`=0x00 one cycle later. All outputs read 0 during reset.
- `ld_start`, stream 0x10,0x11,0x12 with `ld_last` on the third byte -> `cpu_hold` high for 3 cycles, `ld_done` pulses, `ld_count`=3, then reads of addresses 0..2 return 0x10..0x12.
- Stream 64 bytes with no `ld_last` -> auto-finish after address 63, `ld_count`=64, address 0 not overwritten.
- `wr_mem` address 20 with 0xA5, then `rd_mem` address 20 -> 0xA5. `rd_mem`+`wr_mem` together at address 20 with 0x5A -> write happens, output stays 0xA5.
- With `MEM_ROM_PROTECT_EN`: `wr_mem` address 3 with 0xFF -> mem[3] unchanged and `wp_fault`=1. Without the macro -> mem[3]=0xFF and `wp_fault`=0.
- Assert `reset` after 2 of 5 loaded bytes -> IDLE, `cpu_hold`=0, addresses 0..1 keep their loaded data.
